// File: rtl/pulse_burst_det.sv
// pulse_burst_det
// Receive-side checker for fixed-format pulse bursts. It samples din on every
// rising clock edge and accepts a burst made of exactly PULSES high runs of
// HI_LEN cycles. The high runs are separated by low runs of LO_LEN cycles, and
// the burst ends with GAP consecutive low cycles. It then issues exactly one
// verdict per burst.
//
// Parameters:
//   HI_LEN  required high-run length (>=1)
//   LO_LEN  required low-run length between pulses (>=1)
//   PULSES  required pulse count per burst (>=1)
//   GAP     consecutive lows that terminate a burst (> LO_LEN)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        burst line, already synchronous to clk
//   burst_ok   one-cycle pulse, valid burst completed
//   burst_err  one-cycle pulse, malformed burst detected
//   busy       high while a burst (or error recovery) is in progress
//   pulse_cnt  pulses accepted in the current burst, held while idle
module pulse_burst_det #(
    parameter int HI_LEN = 2,
    parameter int LO_LEN = 1,
    parameter int PULSES = 3,
    parameter int GAP    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din,
    output logic                        burst_ok,
    output logic                        burst_err,
    output logic                        busy,
    output logic [$clog2(PULSES+1)-1:0] pulse_cnt
);

    localparam int RUN_MAX = (HI_LEN > GAP) ? HI_LEN : GAP;
    localparam int RW      = $clog2(RUN_MAX + 1);
    localparam int PW      = $clog2(PULSES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        ERR
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   run_cnt, run_n, run_inc;
    logic [PW-1:0]   pcnt_n, pcnt_inc;
    logic            ok_n, err_n;

    // Saturating increments: neither counter may ever wrap back to zero.
    assign run_inc  = (run_cnt == RW'(RUN_MAX)) ? run_cnt : run_cnt + RW'(1);
    assign pcnt_inc = (pulse_cnt == PW'(PULSES)) ? pulse_cnt : pulse_cnt + PW'(1);

    // Next-state logic.
    // In HIGH and LOW, run_cnt holds the number of samples already seen in the
    // current run. ERR reuses run_cnt to count the low samples that must be
    // seen in a row before the checker returns to idle.
    always_comb begin
        state_n = state;
        run_n   = run_cnt;
        pcnt_n  = pulse_cnt;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (din) begin
                    state_n = HIGH;
                    run_n   = RW'(1);
                    pcnt_n  = '0;
                end
            end
            HIGH: begin
                if (din) begin
                    if (run_cnt < RW'(HI_LEN)) begin
                        run_n = run_inc;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                        run_n   = '0;
                    end
                end else if (run_cnt == RW'(HI_LEN)) begin
                    pcnt_n  = pcnt_inc;
                    state_n = LOW;
                    run_n   = RW'(1);
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    run_n   = '0;
                end
            end
            LOW: begin
                if (!din) begin
                    run_n = run_inc;
                    if (run_inc == RW'(GAP)) begin
                        state_n = IDLE;
                        run_n   = '0;
                        if (pulse_cnt == PW'(PULSES)) begin
                            ok_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if (run_cnt == RW'(LO_LEN) && pulse_cnt < PW'(PULSES)) begin
                    state_n = HIGH;
                    run_n   = RW'(1);
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    run_n   = '0;
                end
            end
            ERR: begin
                // Only a full quiet gap releases the checker; any high restarts it.
                if (din) begin
                    run_n = '0;
                end else begin
                    run_n = run_inc;
                    if (run_inc == RW'(GAP)) begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                run_n   = '0;
            end
        endcase
    end

    // State and output registers.
    // busy is taken from the next state. It therefore falls in the same cycle
    // that the verdict pulse appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            run_cnt   <= '0;
            pulse_cnt <= '0;
            burst_ok  <= 1'b0;
            burst_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            run_cnt   <= run_n;
            pulse_cnt <= pcnt_n;
            burst_ok  <= ok_n;
            burst_err <= err_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: doc/pulse_burst_det.md
# pulse_burst_det

Receive-side checker for the fixed-format pulse bursts emitted by the team's burst generators. It samples a single-bit line `din` in the `clk` domain and validates each burst: exactly PULSES high runs of HI_LEN cycles, separated by low runs of LO_LEN cycles, terminated by an idle gap. It then reports a one-cycle `burst_ok` or `burst_err` verdict. It sits directly downstream of a same-clock burst transmitter, in loopback tests or as a link monitor.

## Interface
- HI_LEN, default 2: required high-run length in cycles; must be ≥1.
- LO_LEN, default 1: required low-run length between pulses; must be ≥1.
- PULSES, default 3: required pulses per burst; must be ≥1.
- GAP, default 4: consecutive low cycles that end a burst; must be > LO_LEN.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  burst line, synchronous to `clk`; no internal synchroniser.
- burst_ok  output  1  one-cycle pulse: a valid burst completed.
- burst_err  output  1  one-cycle pulse: a malformed burst was detected.
- busy  output  1  high while the FSM is not IDLE.
- pulse_cnt  output  $clog2(PULSES+1)  pulses accepted in the current burst; holds its last value in IDLE.

## Operation
- Counters:
  - `run_cnt` counts the length of the current run. Its width is $clog2(max(HI_LEN,GAP)+1); it saturates and never wraps.
  - `pulse_cnt` saturates at PULSES.
- FSM states: IDLE, HIGH, LOW, ERR. Every transition happens on a sampled value of `din`.
- IDLE:
  - din=1 → HIGH, run_cnt=1, pulse_cnt=0.
  - din=0 → stay in IDLE.
- HIGH:
  - din=1 with run_cnt<HI_LEN → run_cnt+1.
  - din=1 with run_cnt==HI_LEN (pulse too long) → ERR.
  - din=0 with run_cnt==HI_LEN → pulse_cnt+1, go to LOW, run_cnt=1.
  - din=0 with run_cnt<HI_LEN (pulse too short) → ERR.
- LOW:
  - din=0: run_cnt+1. When run_cnt reaches GAP:
    - pulse_cnt==PULSES → pulse burst_ok, go to IDLE.
    - otherwise (too few pulses) → pulse burst_err, go to IDLE.
  - din=1 with run_cnt==LO_LEN and pulse_cnt<PULSES → HIGH, run_cnt=1.
  - din=1 in any other case (gap wrong length, or an extra pulse) → ERR.
- ERR:
  - burst_err pulses once, on entry only.
  - The FSM waits for GAP consecutive low samples; any high sample restarts that count. It then goes to IDLE with no second verdict.
- Each burst produces exactly one verdict: either burst_ok or burst_err, never both and never more than one.

## Timing
- Reset values: burst_ok=0, burst_err=0, busy=0, pulse_cnt=0, state=IDLE, run_cnt=0.
- Reset mid-burst aborts it immediately, with no verdict.
- All outputs are registered.
- Verdict latency:
  - burst_ok/burst_err is high in the cycle after the edge that samples the deciding din value, for example the GAP-th low.
  - On ERR entry, burst_err rises in the cycle after the offending sample.
- busy rises in the cycle after the first high sample. It falls in the same cycle that burst_ok or the ERR-exit takes effect.
- pulse_cnt updates in the cycle after the falling-edge sample that completes a pulse.
- Back-to-back bursts:
  - A high sample in IDLE is accepted on the cycle immediately after the verdict cycle.
  - A high sample during the last GAP cycles is handled by the LOW rules above.
- din held high indefinitely from IDLE → exactly one burst_err, after HI_LEN+1 high samples.
- din held low: the FSM stays in IDLE with no outputs.

## Test plan
- Defaults; din = 1,1,0,1,1,0,1,1,0,0,0,0 from IDLE → burst_ok pulses once, in the cycle after sample 12; pulse_cnt=3; burst_err never asserts.
- Defaults; din = 1,1,1 → burst_err pulses in the cycle after sample 3. Then din = 0×4 → busy falls and there is no second verdict.
- Defaults; two pulses, then 0×4 → burst_err (too few) in the cycle after the 4th low; pulse_cnt=2.
- Defaults; a valid 3-pulse burst, then din=1 after a single low sample (a 4th pulse) → burst_err. burst_ok must never assert.
- Two valid bursts with no idle between the verdict and the next high → two burst_ok pulses, 12 cycles apart.
- rst asserted asynchronously after sample 5 of a valid burst, then a full valid burst → all outputs read 0 during reset, then exactly one burst_ok.
